sr_cmd_sequencer: RTL and testbench

Command front-end for the SR flip-flop stage: buffers set/reset requests from control logic and converts them into clean, mutually exclusive `s`/`r` pulses, so the downstream flip-flop never sees the invalid `s=r=1` input. Requests arrive on a valid/ready handshake, queue in a small FIFO and issue in order. Each issue is a pulse of programmable width, followed by a programmable idle gap.

---
 rtl/sr_cmd_sequencer_if.sv | 10 +
 rtl/sr_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_sequencer_if.sv
// Command handshake for sr_cmd_sequencer.
// master: control logic issuing set/reset requests; slave: the sequencer.
interface sr_cmd_sequencer_if;
  logic cmd_valid;  // request present
  logic cmd_op;     // 1 = set, 0 = reset
  logic cmd_ready;  // sequencer FIFO can accept

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: buffers set/reset requests in a small FIFO and replays them
// as mutually exclusive, registered s/r pulses of PULSE_W cycles followed by
// GAP_W idle cycles, so the downstream SR flip-flop never sees s=r=1.
// Optional build macro SR_CMD_SEQ_SKIP_REDUNDANT_EN: a popped command whose op
// already matches shadow_q is dropped (the pop still spends its IDLE cycle).
module sr_cmd_sequencer #(
  parameter int DEPTH   = 4,  // FIFO entries, power of two, >= 2
  parameter int PULSE_W = 1,  // cycles s or r is held high, >= 1
  parameter int GAP_W   = 1   // idle cycles after each pulse, >= 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sr_cmd_sequencer_if.slave        cmd_if,
  output logic                     s,
  output logic                     r,
  output logic                     shadow_q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_M1  = (GAP_W > 0) ? GAP_W - 1 : 0;

  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_M1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  // Sequencer state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             op_q, op_d;
  logic             shadow_st_q, shadow_st_d;

  logic push, pop, drop, issue, head_op;

  // Ready depends only on registered occupancy; a pop never frees a slot
  // for a push on the same edge.
  assign cmd_if.cmd_ready = (count_q != FULL_CNT);
  assign push    = cmd_if.cmd_valid & cmd_if.cmd_ready;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign head_op = mem_q[rd_ptr_q];

`ifdef SR_CMD_SEQ_SKIP_REDUNDANT_EN
  // A command that would not change the flip-flop is consumed silently.
  assign drop = (head_op == shadow_st_q);
`else
  assign drop = 1'b0;
`endif

  assign issue = pop & ~drop;

  // Occupancy: push and pop on the same edge leave count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy register; pointers wrap modulo DEPTH.
  // NOTE: clocked state always uses non-blocking (<=) so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO payload write.
  // NOTE: payload storage has no reset; entries are only read after count
  // says they were written, so resetting them would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_if.cmd_op;
  end

  // Sequencer next-state: pop/issue in IDLE, time the pulse, then the gap.
  // NOTE: every signal assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    s_d         = s_q;
    r_d         = r_q;
    op_d        = op_q;
    shadow_st_d = shadow_st_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = PULSE;
          tmr_d   = PULSE_LOAD;
          op_d    = head_op;
          s_d     = head_op;
          r_d     = ~head_op;
        end
      end
      PULSE: begin
        if (tmr_q == '0) begin
          s_d         = 1'b0;
          r_d         = 1'b0;
          shadow_st_d = op_q;
          if (GAP_W > 0) begin
            state_d = GAP;
            tmr_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset kills any pulse in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      op_q        <= 1'b0;
      shadow_st_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      s_q         <= s_d;
      r_q         <= r_d;
      op_q        <= op_d;
      shadow_st_q <= shadow_st_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign shadow_q = shadow_st_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Testbench for sr_cmd_sequencer: three instances with different pulse/gap
// timing, a per-instance scoreboard of expected pulse ops, and table-driven
// plus hand-written sequences.
module tb_sr_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PW_A = 1, GW_A = 1;
  localparam int PW_B = 2, GW_B = 0;
  localparam int PW_C = 4, GW_C = 1;

  logic clk;
  logic rst_n;

  sr_cmd_sequencer_if if_a ();
  sr_cmd_sequencer_if if_b ();
  sr_cmd_sequencer_if if_c ();

  logic s_a, r_a, sh_a, busy_a;
  logic s_b, r_b, sh_b, busy_b;
  logic s_c, r_c, sh_c, busy_c;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c;

  sr_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_W(PW_A), .GAP_W(GW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_if(if_a), .s(s_a), .r(r_a),
    .shadow_q(sh_a), .count(cnt_a), .busy(busy_a));
  sr_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_W(PW_B), .GAP_W(GW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_if(if_b), .s(s_b), .r(r_b),
    .shadow_q(sh_b), .count(cnt_b), .busy(busy_b));
  sr_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_W(PW_C), .GAP_W(GW_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .cmd_if(if_c), .s(s_c), .r(r_c),
    .shadow_q(sh_c), .count(cnt_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-instance accessors ----------------
  function automatic logic get_s(input int d);
    case (d) 0: return s_a; 1: return s_b; default: return s_c; endcase
  endfunction
  function automatic logic get_r(input int d);
    case (d) 0: return r_a; 1: return r_b; default: return r_c; endcase
  endfunction
  function automatic logic get_busy(input int d);
    case (d) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic int pw_of(input int d);
    case (d) 0: return PW_A; 1: return PW_B; default: return PW_C; endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic op);
    case (d)
      0:       begin if_a.cmd_valid = v; if_a.cmd_op = op; end
      1:       begin if_b.cmd_valid = v; if_b.cmd_op = op; end
      default: begin if_c.cmd_valid = v; if_c.cmd_op = op; end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  bit   q_a[$], q_b[$], q_c[$];
  logic m_shadow [3];
  int   run_len  [3];

  function automatic void sb_push(input int d, input bit op);
    case (d) 0: q_a.push_back(op); 1: q_b.push_back(op); default: q_c.push_back(op); endcase
  endfunction
  function automatic int sb_size(input int d);
    case (d) 0: return q_a.size(); 1: return q_b.size(); default: return q_c.size(); endcase
  endfunction
  function automatic bit sb_pop(input int d);
    case (d) 0: return q_a.pop_front(); 1: return q_b.pop_front(); default: return q_c.pop_front(); endcase
  endfunction

  // Model of what each pushed command will do at issue time.
  task automatic model_push(input int d, input logic op);
`ifdef SR_CMD_SEQ_SKIP_REDUNDANT_EN
    if (op == m_shadow[d]) return;
`endif
    m_shadow[d] = op;
    sb_push(d, op);
  endtask

  task automatic model_reset();
    q_a.delete(); q_b.delete(); q_c.delete();
    for (int d = 0; d < 3; d++) m_shadow[d] = 1'b0;
  endtask

  // Pulse monitor: each rising pulse must match the next expected op,
  // last exactly PULSE_W cycles, and s/r must never be high together.
  always @(negedge clk) begin : monitor
    logic sv, rv, eop;
    for (int d = 0; d < 3; d++) begin
      sv = get_s(d);
      rv = get_r(d);
      if (!rst_n) begin
        check($sformatf("sr_low_in_reset_dut%0d", d), 32'({sv, rv}), 32'd0);
        run_len[d] = 0;
      end else begin
        check($sformatf("s_and_r_exclusive_dut%0d", d), 32'(sv & rv), 32'd0);
        if (sv | rv) begin
          if (run_len[d] == 0) begin
            if (sb_size(d) == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_pulse_dut%0d: got s=%0b r=%0b, expected no pulse (t=%0t)",
                       d, sv, rv, $time);
            end else begin
              eop = sb_pop(d);
              check($sformatf("pulse_op_dut%0d", d), 32'(sv), 32'(eop));
            end
          end
          run_len[d]++;
        end else if (run_len[d] != 0) begin
          check($sformatf("pulse_width_dut%0d", d), 32'(run_len[d]), 32'(pw_of(d)));
          run_len[d] = 0;
        end
      end
    end
  end

  task automatic wait_idle(input int d, input string name);
    int cyc;
    cyc = 0;
    while (get_busy(d) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(get_busy(d)), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Table record for single-command transactions on dut_a.
  typedef struct {
    logic op;
    logic exp_s;     // s after the pop edge
    logic exp_r;     // r after the pop edge
    logic exp_sh;    // shadow_q after the pulse ends
    logic exp_busy;  // busy after the pop edge
  } vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs [6];
    logic fo [6];
    int   fc [5];
    int   fc2 [4];
    logic fr2 [4];
    logic ao [3];
    logic as_s [9];
    logic as_r [9];
    logic so [5];
    logic sv_v [5];
    int   sc [5];

`ifdef SR_CMD_SEQ_SKIP_REDUNDANT_EN
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};  // set issues
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // redundant set dropped
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};  // reset issues
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // redundant reset dropped
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    fo   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    fc   = '{1, 1, 2, 3, 4};
    fc2  = '{4, 4, 3, 4};
    fr2  = '{1'b0, 1'b0, 1'b1, 1'b0};
    ao   = '{1'b1, 1'b0, 1'b1};
    as_s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    as_r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    so   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    sv_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    sc   = '{1, 1, 2, 2, 2};

    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0);
    model_reset();
    for (int d = 0; d < 3; d++) run_len[d] = 0;

    // ---- reset state (asynchronous, before any clock edge) ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_s",      32'(s_a), 32'd0);
    check("rst_r",      32'(r_a), 32'd0);
    check("rst_shadow", 32'(sh_a), 32'd0);
    check("rst_count",  32'(cnt_a), 32'd0);
    check("rst_busy",   32'(busy_a), 32'd0);
    check("rst_ready",  32'(if_a.cmd_ready), 32'd1);
    check("rst_sr_b",   32'({s_b, r_b}), 32'd0);
    check("rst_sr_c",   32'({s_c, r_c}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table: single commands on dut_a (PULSE_W=1, GAP_W=1) ----
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, vecs[i].op);
      model_push(0, vecs[i].op);
      @(posedge clk); #1;                       // E0: accepted
      drive(0, 1'b0, 1'b0);
      check($sformatf("vec%0d_count", i), 32'(cnt_a), 32'd1);
      check($sformatf("vec%0d_pre_sr", i), 32'({s_a, r_a}), 32'd0);
      @(posedge clk); #1;                       // E0+1: popped
      check($sformatf("vec%0d_s", i), 32'(s_a), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d_r", i), 32'(r_a), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].exp_busy));
      @(posedge clk); #1;                       // E0+2: pulse over
      check($sformatf("vec%0d_shadow", i), 32'(sh_a), 32'(vecs[i].exp_sh));
      check($sformatf("vec%0d_fall", i), 32'({s_a, r_a}), 32'd0);
      @(posedge clk); #1;                       // E0+3: back in IDLE
      check($sformatf("vec%0d_idle", i), 32'(busy_a), 32'd0);
    end

    // ---- fill dut_c (PULSE_W=4) while it is pulsing ----
    for (int i = 0; i < 5; i++) begin
      drive(2, 1'b1, fo[i]);
      model_push(2, fo[i]);
      @(posedge clk); #1;
      check($sformatf("fill_count_%0d", i), 32'(cnt_c), 32'(fc[i]));
    end
    check("fill_ready_low", 32'(if_c.cmd_ready), 32'd0);
    drive(2, 1'b1, fo[5]);
    model_push(2, fo[5]);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check($sformatf("fill_held_count_%0d", j), 32'(cnt_c), 32'(fc2[j]));
      check($sformatf("fill_held_ready_%0d", j), 32'(if_c.cmd_ready), 32'(fr2[j]));
      if (j == 0) check("fill_first_shadow", 32'(sh_c), 32'd1);
    end
    drive(2, 1'b0, 1'b0);
    wait_idle(2, "fill_drain");

    // ---- alternating set/reset/set on dut_b (PULSE_W=2, GAP_W=0) ----
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        drive(1, 1'b1, ao[k]);
        model_push(1, ao[k]);
      end else begin
        drive(1, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        check($sformatf("alt_s_%0d", k), 32'(s_b), 32'(as_s[k-1]));
        check($sformatf("alt_r_%0d", k), 32'(r_b), 32'(as_r[k-1]));
      end
    end
    wait_idle(1, "alt_drain");
    check("alt_shadow", 32'(sh_b), 32'd1);

    // ---- simultaneous push and pop at count=2 on dut_a ----
    for (int k = 0; k < 5; k++) begin
      drive(0, sv_v[k], so[k]);
      if (sv_v[k]) model_push(0, so[k]);
      @(posedge clk); #1;
      check($sformatf("pushpop_count_%0d", k), 32'(cnt_a), 32'(sc[k]));
    end
    drive(0, 1'b0, 1'b0);
    wait_idle(0, "pushpop_drain");

    // ---- async reset in the middle of a PULSE_W=4 pulse on dut_c ----
    drive(2, 1'b1, 1'b1);
    model_push(2, 1'b1);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0);
    wait_idle(2, "pre_reset_drain");
    check("pre_reset_shadow", 32'(sh_c), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(2, 1'b1, fo[k+1]);                  // 0, 1, 0
      model_push(2, fo[k+1]);
      @(posedge clk); #1;
    end
    drive(2, 1'b0, 1'b0);
    check("midpulse_r_high", 32'(r_c), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;                                         // still before the next edge
    check("async_rst_r",      32'(r_c), 32'd0);
    check("async_rst_s",      32'(s_c), 32'd0);
    check("async_rst_count",  32'(cnt_c), 32'd0);
    check("async_rst_shadow", 32'(sh_c), 32'd0);
    check("async_rst_busy",   32'(busy_c), 32'd0);
    check("async_rst_ready",  32'(if_c.cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_count",  32'(cnt_c), 32'd0);
    check("post_rst_busy",   32'(busy_c), 32'd0);
    check("post_rst_shadow", 32'(sh_c), 32'd0);

    // ---- every expected pulse was observed ----
    check("sb_empty_a", 32'(q_a.size()), 32'd0);
    check("sb_empty_b", 32'(q_b.size()), 32'd0);
    check("sb_empty_c", 32'(q_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
